// File: rtl/sar_adc_if.sv
// Core/comparator-facing signal bundle of the SAR ADC controller.
// The master side requests conversions and supplies the comparator bit.
interface sar_adc_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             abort;
  logic             cmp_in;
  logic             sample;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data;

  modport master (
    output start, abort, cmp_in,
    input  sample, dac_code, busy, done, data
  );

  modport slave (
    input  start, abort, cmp_in,
    output sample, dac_code, busy, done, data
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track/hold sample phase, then a
// MSB-first binary search of a trial DAC code driven by a single comparator bit.
module sar_adc_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic     clk,
  input  logic     reset,
  sar_adc_if.slave bus
);

  localparam int               IDX_W       = $clog2(WIDTH);
  localparam logic [7:0]       SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [WIDTH-1:0] CODE_MSB    = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, COMPARE, DONE} state_t;

  state_t           state_q, state_n;
  logic [7:0]       cnt_q, cnt_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [WIDTH-1:0] code_q, code_n;
  logic [WIDTH-1:0] data_q, data_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      code_q  <= code_n;
      data_q  <= data_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    code_n  = code_q;
    data_n  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_n = SAMPLE;
          cnt_n   = '0;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_q == SAMPLE_LAST) begin
          state_n = SETTLE;
          cnt_n   = '0;
          idx_n   = IDX_TOP;
          code_n  = CODE_MSB;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_n = COMPARE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      COMPARE: begin
        // Resolve the current bit, then either arm the next lower bit or finish.
        if (bus.abort) begin
          state_n = IDLE;
        end else begin
          if (!bus.cmp_in) code_n[idx_q] = 1'b0;
          if (idx_q != '0) begin
            code_n[idx_q - IDX_ONE] = 1'b1;
            idx_n                   = idx_q - IDX_ONE;
            state_n                 = SETTLE;
          end else begin
            data_n  = code_n;
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state, so no input reaches them combinationally.
  assign bus.sample   = (state_q == SAMPLE);
  assign bus.busy     = (state_q == SAMPLE) || (state_q == SETTLE) || (state_q == COMPARE);
  assign bus.done     = (state_q == DONE);
  assign bus.dac_code = ((state_q == SETTLE) || (state_q == COMPARE)) ? code_q : '0;
  assign bus.data     = data_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with an ideal comparator on a 10-bit input code.
module tb_sar_adc_ctrl;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] vin_code = '0;

  sar_adc_if #(.WIDTH(W)) bus ();

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.cmp_in = (vin_code >= bus.dac_code);

  int n_chk  = 0;
  int n_fail = 0;

  logic         tr_sample [0:63];
  logic         tr_busy   [0:63];
  logic         tr_done   [0:63];
  logic [W-1:0] tr_dac    [0:63];
  int           first_done, last_done, n_done;

  logic [W-1:0] exp_trial [0:9] = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0,
                                    10'h2B0, 10'h2A8, 10'h2A4, 10'h2A6, 10'h2A5};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at edge 0; trace index c is the cycle following edge c-1.
  task automatic run(input logic [W-1:0] vin, input int ncyc, input bit hold,
                     input int x1, input int x2, input int x3,
                     input int abort_c, input int rst_c);
    vin_code   = vin;
    bus.start  = 1'b1;
    first_done = -1;
    last_done  = -1;
    n_done     = 0;
    tick();
    for (int c = 1; c <= ncyc; c++) begin
      bus.start     = hold || (c == x1) || (c == x2) || (c == x3);
      bus.abort     = (c == abort_c);
      reset         = (c == rst_c);
      tr_sample[c]  = bus.sample;
      tr_busy[c]    = bus.busy;
      tr_done[c]    = bus.done;
      tr_dac[c]     = bus.dac_code;
      if (bus.done) begin
        n_done++;
        if (first_done < 0) first_done = c;
        last_done = c;
      end
      tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " sample"}, 32'(bus.sample), 32'd0);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd0);
    check({tag, " dac"}, 32'(bus.dac_code), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    reset     = 1'b1;
    repeat (3) tick();
    check_idle("reset");
    check("reset data", 32'(bus.data), 32'd0);
    reset = 1'b0;
    tick();
    check_idle("post-reset");

    // Reference conversion with full trace
    run(10'h2A5, 26, 1'b0, -1, -1, -1, -1, -1);
    for (int c = 1; c <= 26; c++) begin
      check($sformatf("sample c%0d", c), 32'(tr_sample[c]), 32'(c <= 4));
      check($sformatf("busy c%0d", c), 32'(tr_busy[c]), 32'(c <= 24));
      if (c <= 4 || c >= 25) check($sformatf("dac zero c%0d", c), 32'(tr_dac[c]), 32'd0);
    end
    for (int k = 0; k < 10; k++) begin
      check($sformatf("trial settle %0d", k), 32'(tr_dac[5 + 2*k]), 32'(exp_trial[k]));
      check($sformatf("trial compare %0d", k), 32'(tr_dac[6 + 2*k]), 32'(exp_trial[k]));
    end
    check("2A5 done cycle", 32'(first_done), 32'd25);
    check("2A5 done count", 32'(n_done), 32'd1);
    check("2A5 data", 32'(bus.data), 32'h2A5);

    // Abort mid-conversion keeps previous result
    run(10'h155, 26, 1'b0, -1, -1, -1, 10, -1);
    check("abort busy c10", 32'(tr_busy[10]), 32'd1);
    check("abort busy c11", 32'(tr_busy[11]), 32'd0);
    check("abort dac c11", 32'(tr_dac[11]), 32'd0);
    check("abort sample c11", 32'(tr_sample[11]), 32'd0);
    check("abort done count", 32'(n_done), 32'd0);
    check("abort data", 32'(bus.data), 32'h2A5);

    // Extra starts while busy and in DONE are ignored
    run(10'h000, 26, 1'b0, 3, 12, 25, -1, -1);
    check("000 done cycle", 32'(first_done), 32'd25);
    check("000 done count", 32'(n_done), 32'd1);
    check("000 data", 32'(bus.data), 32'h000);
    check("000 idle c26", 32'(tr_busy[26]), 32'd0);
    check("000 sample c26", 32'(tr_sample[26]), 32'd0);

    run(10'h3FF, 26, 1'b0, -1, -1, -1, -1, -1);
    check("3FF done cycle", 32'(first_done), 32'd25);
    check("3FF data", 32'(bus.data), 32'h3FF);

    run(10'h200, 26, 1'b0, -1, -1, -1, -1, -1);
    check("200 done cycle", 32'(first_done), 32'd25);
    check("200 data", 32'(bus.data), 32'h200);

    // Start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    check_idle("start+abort");
    tick();
    check_idle("start+abort 2");
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();
    check_idle("start+abort 3");

    // Reset mid-conversion
    run(10'h3FF, 20, 1'b0, -1, -1, -1, -1, 15);
    check("rst busy c15", 32'(tr_busy[15]), 32'd1);
    check("rst sample c16", 32'(tr_sample[16]), 32'd0);
    check("rst busy c16", 32'(tr_busy[16]), 32'd0);
    check("rst dac c16", 32'(tr_dac[16]), 32'd0);
    check("rst done c16", 32'(tr_done[16]), 32'd0);
    check("rst busy c17", 32'(tr_busy[17]), 32'd0);
    check("rst done count", 32'(n_done), 32'd0);
    check("rst data", 32'(bus.data), 32'd0);

    run(10'h155, 26, 1'b0, -1, -1, -1, -1, -1);
    check("155 done cycle", 32'(first_done), 32'd25);
    check("155 data", 32'(bus.data), 32'h155);

    // Start held high: back-to-back conversions at cycles 0, 26, 52
    run(10'h0F0, 55, 1'b1, -1, -1, -1, -1, -1);
    check("hold first done", 32'(first_done), 32'd25);
    check("hold second done", 32'(last_done), 32'd51);
    check("hold done count", 32'(n_done), 32'd2);
    check("hold sample c26", 32'(tr_sample[26]), 32'd0);
    check("hold sample c27", 32'(tr_sample[27]), 32'd1);
    check("hold sample c53", 32'(tr_sample[53]), 32'd1);
    repeat (30) tick();
    check("hold data", 32'(bus.data), 32'h0F0);
    check_idle("hold drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
